// File: rtl/feature_dispatcher.sv
// rtl/feature_dispatcher.sv - arbitrates two feature-request interfaces into one registered dispatch stream
module feature_dispatcher #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ie1_req,
    input  logic [2:0]       ie1_code,
    output logic             ie1_ack,
    input  logic             ie2_req,
    input  logic [2:0]       ie2_code,
    output logic             ie2_ack,
    output logic             out_valid,
    output logic [2:0]       out_code,
    output logic             out_src,
    input  logic             out_ready,
    output logic             cft_flag,
    output logic [CNT_W-1:0] cft_count,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, ISSUE_A, ISSUE_B} state_t;

    state_t             state, nxt_state;
    logic               ptr, nxt_ptr;
    logic               pending, nxt_pending;
    logic [2:0]         slot_b_code, nxt_slot_b_code;
    logic               slot_b_src, nxt_slot_b_src;
    logic               nxt_ie1_ack, nxt_ie2_ack, nxt_cft_flag;
    logic               nxt_out_valid, nxt_out_src, nxt_busy;
    logic [2:0]         nxt_out_code;
    logic [CNT_W-1:0]   nxt_cft_count;
    logic [2:0]         win_code, lose_code;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Slot A lives directly in out_code/out_src; only slot B needs separate storage.
    always_comb begin
        nxt_state       = state;
        nxt_ptr         = ptr;
        nxt_pending     = pending;
        nxt_slot_b_code = slot_b_code;
        nxt_slot_b_src  = slot_b_src;
        nxt_ie1_ack     = 1'b0;
        nxt_ie2_ack     = 1'b0;
        nxt_cft_flag    = 1'b0;
        nxt_cft_count   = cft_count;
        nxt_out_valid   = out_valid;
        nxt_out_code    = out_code;
        nxt_out_src     = out_src;
        nxt_busy        = busy;
        win_code        = ptr ? ie2_code : ie1_code;
        lose_code       = ptr ? ie1_code : ie2_code;

        case (state)
            IDLE: begin
                if (ie1_req && ie2_req) begin
                    nxt_ptr       = ~ptr;
                    nxt_ie1_ack   = 1'b1;
                    nxt_ie2_ack   = 1'b1;
                    nxt_out_code  = win_code;
                    nxt_out_src   = ptr;
                    nxt_out_valid = 1'b1;
                    nxt_busy      = 1'b1;
                    nxt_state     = ISSUE_A;
                    if (ie1_code == ie2_code) begin
                        nxt_cft_flag = 1'b1;
                        nxt_pending  = 1'b0;
                        if (cft_count != CNT_MAX) begin
                            nxt_cft_count = cft_count + CNT_W'(1);
                        end
                    end else begin
                        nxt_slot_b_code = lose_code;
                        nxt_slot_b_src  = ~ptr;
                        nxt_pending     = 1'b1;
                    end
                end else if (ie1_req || ie2_req) begin
                    nxt_ie1_ack   = ie1_req;
                    nxt_ie2_ack   = ie2_req;
                    nxt_out_code  = ie1_req ? ie1_code : ie2_code;
                    nxt_out_src   = ~ie1_req;
                    nxt_out_valid = 1'b1;
                    nxt_busy      = 1'b1;
                    nxt_pending   = 1'b0;
                    nxt_state     = ISSUE_A;
                end
            end
            ISSUE_A: begin
                if (out_ready) begin
                    if (pending) begin
                        nxt_out_code = slot_b_code;
                        nxt_out_src  = slot_b_src;
                        nxt_state    = ISSUE_B;
                    end else begin
                        nxt_out_valid = 1'b0;
                        nxt_busy      = 1'b0;
                        nxt_state     = IDLE;
                    end
                end
            end
            ISSUE_B: begin
                if (out_ready) begin
                    nxt_out_valid = 1'b0;
                    nxt_busy      = 1'b0;
                    nxt_pending   = 1'b0;
                    nxt_state     = IDLE;
                end
            end
            default: begin
                nxt_out_valid = 1'b0;
                nxt_busy      = 1'b0;
                nxt_pending   = 1'b0;
                nxt_state     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= 1'b0;
            pending     <= 1'b0;
            slot_b_code <= 3'b000;
            slot_b_src  <= 1'b0;
            ie1_ack     <= 1'b0;
            ie2_ack     <= 1'b0;
            cft_flag    <= 1'b0;
            cft_count   <= '0;
            out_valid   <= 1'b0;
            out_code    <= 3'b000;
            out_src     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= nxt_state;
            ptr         <= nxt_ptr;
            pending     <= nxt_pending;
            slot_b_code <= nxt_slot_b_code;
            slot_b_src  <= nxt_slot_b_src;
            ie1_ack     <= nxt_ie1_ack;
            ie2_ack     <= nxt_ie2_ack;
            cft_flag    <= nxt_cft_flag;
            cft_count   <= nxt_cft_count;
            out_valid   <= nxt_out_valid;
            out_code    <= nxt_out_code;
            out_src     <= nxt_out_src;
            busy        <= nxt_busy;
        end
    end

endmodule

// File: tb/tb_feature_dispatcher.sv
// tb/tb_feature_dispatcher.sv - directed self-checking bench for feature_dispatcher
module tb_feature_dispatcher;

    logic       clk = 1'b0;
    logic       rst;
    logic       ie1_req, ie2_req;
    logic [2:0] ie1_code, ie2_code;
    logic       ie1_ack, ie2_ack;
    logic       out_valid, out_src, out_ready;
    logic [2:0] out_code;
    logic       cft_flag, busy;
    logic [7:0] cft_count;

    int n_checks = 0;
    int n_fail   = 0;

    feature_dispatcher #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .ie1_req(ie1_req), .ie1_code(ie1_code), .ie1_ack(ie1_ack),
        .ie2_req(ie2_req), .ie2_code(ie2_code), .ie2_ack(ie2_ack),
        .out_valid(out_valid), .out_code(out_code), .out_src(out_src),
        .out_ready(out_ready), .cft_flag(cft_flag), .cft_count(cft_count),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic r1, input logic [2:0] c1, input logic r2, input logic [2:0] c2);
        ie1_req  = r1;
        ie1_code = c1;
        ie2_req  = r2;
        ie2_code = c2;
    endtask

    initial begin
        rst = 1'b1;
        out_ready = 1'b1;
        set_req(1'b0, 3'b000, 1'b0, 3'b000);
        repeat (3) step();
        check("rst_valid", out_valid, 0);
        check("rst_code", out_code, 0);
        check("rst_busy", busy, 0);
        check("rst_acks", {ie1_ack, ie2_ack, cft_flag}, 0);
        check("rst_count", cft_count, 0);
        rst = 1'b0;
        step();

        // Single request from IE01
        set_req(1'b1, 3'b101, 1'b0, 3'b000);
        step();
        check("single_acks", {ie1_ack, ie2_ack}, 2'b10);
        check("single_out", {out_valid, out_code, out_src}, {1'b1, 3'b101, 1'b0});
        check("single_busy", busy, 1);
        set_req(1'b0, 3'b000, 1'b0, 3'b000);
        step();
        check("single_idle", {out_valid, busy, ie1_ack}, 0);
        check("single_retain", out_code, 3'b101);

        // Ordered pair, pointer 0
        set_req(1'b1, 3'b010, 1'b1, 3'b110);
        step();
        check("pair_acks", {ie1_ack, ie2_ack, cft_flag}, 3'b110);
        check("pair_a", {out_valid, out_code, out_src}, {1'b1, 3'b010, 1'b0});
        set_req(1'b0, 3'b000, 1'b0, 3'b000);
        step();
        check("pair_b", {out_valid, out_code, out_src}, {1'b1, 3'b110, 1'b1});
        check("pair_b_acks", {ie1_ack, ie2_ack}, 0);
        step();
        check("pair_idle", {out_valid, busy}, 0);

        // Conflict, pointer 1
        set_req(1'b1, 3'b011, 1'b1, 3'b011);
        step();
        check("cft_acks", {ie1_ack, ie2_ack, cft_flag}, 3'b111);
        check("cft_out", {out_valid, out_code, out_src}, {1'b1, 3'b011, 1'b1});
        check("cft_count1", cft_count, 1);
        set_req(1'b0, 3'b000, 1'b0, 3'b000);
        step();
        check("cft_single", {out_valid, busy, cft_flag}, 0);

        // Backpressure in ISSUE_A, pointer 0; new IE01 request arrives meanwhile
        out_ready = 1'b0;
        set_req(1'b1, 3'b001, 1'b1, 3'b111);
        step();
        check("bp_a", {out_valid, out_code, out_src}, {1'b1, 3'b001, 1'b0});
        set_req(1'b0, 3'b000, 1'b0, 3'b000);
        step();
        set_req(1'b1, 3'b100, 1'b0, 3'b000);
        for (int i = 0; i < 5; i++) begin
            check("bp_hold", {out_valid, out_code, out_src}, {1'b1, 3'b001, 1'b0});
            check("bp_noack", {ie1_ack, ie2_ack}, 0);
            step();
        end
        out_ready = 1'b1;
        step();
        check("bp_b", {out_valid, out_code, out_src, ie1_ack}, {1'b1, 3'b111, 1'b1, 1'b0});
        step();
        check("bp_idle", {out_valid, ie1_ack}, 0);
        step();
        check("late_req", {ie1_ack, out_valid, out_code, out_src}, {1'b1, 1'b1, 3'b100, 1'b0});
        set_req(1'b0, 3'b000, 1'b0, 3'b000);
        step();
        check("late_idle", out_valid, 0);

        // Reset during ISSUE_A with B pending, pointer 1
        out_ready = 1'b0;
        set_req(1'b1, 3'b010, 1'b1, 3'b001);
        step();
        check("mid_a", {out_valid, out_code, out_src, busy}, {1'b1, 3'b001, 1'b1, 1'b1});
        set_req(1'b0, 3'b000, 1'b0, 3'b000);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_out", {out_valid, out_code, out_src, busy}, 0);
        check("mid_rst_cnt", cft_count, 0);
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("post_rst_quiet", {out_valid, ie1_ack, ie2_ack}, 0);
        end

        // Pointer restarts at 0 after reset
        set_req(1'b1, 3'b101, 1'b1, 3'b011);
        step();
        check("rst_ptr_a", {out_code, out_src}, {3'b101, 1'b0});
        set_req(1'b0, 3'b000, 1'b0, 3'b000);
        step();
        check("rst_ptr_b", {out_valid, out_code, out_src}, {1'b1, 3'b011, 1'b1});
        step();

        // Saturation of the conflict counter
        for (int i = 0; i < 260; i++) begin
            set_req(1'b1, 3'(i), 1'b1, 3'(i));
            step();
            check("sat_flag", cft_flag, 1);
            set_req(1'b0, 3'b000, 1'b0, 3'b000);
            step();
            if (i == 254) check("sat_255", cft_count, 255);
        end
        check("sat_final", cft_count, 255);
        check("sat_flag_off", cft_flag, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
